// File: rtl/uart_rx_if.sv
// UART receive-side signal bundle: oversample tick and serial pin in, word/done/error out.
// Latency: none, wiring only.
// Backpressure: none; the consumer must take rx_data in the rx_done_tick cycle.
interface uart_rx_if #(
   parameter int DATA_BIT = 8
);
   logic                s_tick;
   logic                rx;
   logic [DATA_BIT-1:0] rx_data;
   logic                rx_done_tick;
   logic                frame_err;

   // Driver side: supplies tick and serial line, observes received words.
   modport master (
      output s_tick, rx,
      input  rx_data, rx_done_tick, frame_err
   );

   // Receiver side.
   modport slave (
      input  s_tick, rx,
      output rx_data, rx_done_tick, frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop sync, start-edge detect, mid-bit sampling at OVERSAMPLE x baud.
// Latency: done/frame_err pulse one cycle after the mid-stop-bit s_tick of the last stop bit.
// Backpressure: none; rx_data holds until the next frame completes.
module uart_rx #(
   parameter int DATA_BIT   = 8,
   parameter int STOP_BIT   = 1,
   parameter int OVERSAMPLE = 16
) (
   input logic     clk,
   input logic     reset_n,
   uart_rx_if.slave bus
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int NW = $clog2(DATA_BIT);
   localparam logic [SW-1:0] S_HALF  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_DLAST = NW'(DATA_BIT - 1);
   localparam logic [NW-1:0] N_SLAST = NW'(STOP_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       s_cnt_q, s_cnt_d;
   logic [NW-1:0]       n_cnt_q, n_cnt_d;
   logic [DATA_BIT-1:0] sh_q, sh_d;
   logic                err_q, err_d;
   logic [DATA_BIT-1:0] data_q, data_d;
   logic                done_q, done_d;
   logic                ferr_q, ferr_d;
   logic                rx_s1, rx_s2, rx_prev;
   logic                start_det;

   // Synchronize the asynchronous pin and keep one delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= bus.rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Falling edge only, so a held-low break line cannot re-arm the receiver.
   assign start_det = rx_prev & ~rx_s2;

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         s_cnt_q <= '0;
         n_cnt_q <= '0;
         sh_q    <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         n_cnt_q <= n_cnt_d;
         sh_q    <= sh_d;
         err_q   <= err_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state logic: counters move only on s_tick; n_cnt counts data bits, then stop bits.
   always_comb begin
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      n_cnt_d = n_cnt_q;
      sh_d    = sh_q;
      err_d   = err_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_det) begin
               state_d = START;
               s_cnt_d = '0;
               n_cnt_d = '0;
               err_d   = 1'b0;
            end
         end
         START: begin
            if (bus.s_tick) begin
               if (s_cnt_q == S_HALF) begin
                  // Still low at mid start bit: genuine start; otherwise a glitch.
                  s_cnt_d = '0;
                  state_d = rx_s2 ? IDLE : DATA;
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
         end
         DATA: begin
            if (bus.s_tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d = '0;
                  sh_d    = {rx_s2, sh_q[DATA_BIT-1:1]};
                  if (n_cnt_q == N_DLAST) begin
                     n_cnt_d = '0;
                     state_d = STOP;
                  end else begin
                     n_cnt_d = n_cnt_q + NW'(1);
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
         end
         STOP: begin
            if (bus.s_tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d = '0;
                  err_d   = err_q | ~rx_s2;
                  if (n_cnt_q == N_SLAST) begin
                     // Leave at mid stop bit so a back-to-back start edge is caught.
                     state_d = IDLE;
                     n_cnt_d = '0;
                     data_d  = sh_q;
                     done_d  = 1'b1;
                     ferr_d  = err_d;
                  end else begin
                     n_cnt_d = n_cnt_q + NW'(1);
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.rx_data      = data_q;
   assign bus.rx_done_tick = done_q;
   assign bus.frame_err    = ferr_q;
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive path of the `uart` wrapper, paired with `uart_tx` and driven by the same `uart_baudrate_gen` `s_tick`. It synchronizes the asynchronous `rx` pin and detects the start-bit falling edge. It samples each bit at mid-bit using 16x oversampling, then delivers one `DATA_BIT`-wide word per frame with a one-cycle done pulse and a framing-error flag.

## Interface
- `DATA_BIT`, 8: data bits per frame, 5..8, LSB first.
- `STOP_BIT`, 1: stop bits per frame, 1 or 2.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period. Must be even and ≥ 4.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `s_tick` in 1: one-cycle enable pulse at `OVERSAMPLE` × baud rate (from `uart_baudrate_gen`).
- `rx` in 1: serial input, asynchronous to `clk`, idle high.
- `rx_data` out `DATA_BIT`: last received word. Holds its value between frames.
- `rx_done_tick` out 1: one-cycle pulse, `rx_data` valid in that cycle.
- `frame_err` out 1: one-cycle pulse coincident with `rx_done_tick` when any stop bit is sampled 0.

## Operation
- Synchronizer: `rx` passes through two flops (`rx_s1`, `rx_s2`), plus a third flop `rx_prev` for edge detection. All three reset to 1.
- Start detect: the cycle where `rx_prev`=1 and `rx_s2`=0. Detection is edge-based, so a line held low (break) never re-arms the receiver until it returns high.
- State machine, states IDLE, START, DATA, STOP:
  - IDLE: on start detect, go to START with `s_cnt`=0 and `n_cnt`=0.
  - START: on each `s_tick`, `s_cnt`++. On the `s_tick` where `s_cnt`=`OVERSAMPLE`/2−1 (mid start bit):
    - if `rx_s2`=0, go to DATA with `s_cnt`=0;
    - otherwise the start bit was a glitch: go to IDLE with no output.
  - DATA: on the `s_tick` where `s_cnt`=`OVERSAMPLE`−1:
    - shift `rx_s2` into the shift register MSB and shift right (LSB-first assembly), `s_cnt`=0;
    - if `n_cnt`=`DATA_BIT`−1, go to STOP with `n_cnt`=0; otherwise `n_cnt`++.
  - STOP: on the `s_tick` where `s_cnt`=`OVERSAMPLE`−1:
    - sample the stop bit and OR its inverse into a sticky error bit, `s_cnt`=0;
    - after the `STOP_BIT`-th sample, go to IDLE.
    - On that same cycle, load `rx_data`, pulse `rx_done_tick`, and pulse `frame_err` if the error bit is set.
- The receiver returns to IDLE at mid-stop-bit, so a following start edge is never missed (back-to-back frames).
- Counters: `s_cnt` is $clog2(`OVERSAMPLE`) bits and `n_cnt` is $clog2(`DATA_BIT`) bits. Neither counter wraps past its terminal value.
- Data is delivered even on a framing error; `frame_err` qualifies it.
- `s_cnt` only advances on cycles where `s_tick`=1. All other cycles hold state.

## Timing
- Reset values (`reset_n`=0 at a rising edge):
  - state IDLE;
  - `s_cnt`, `n_cnt`, shift register, error bit = 0;
  - `rx_data`=0, `rx_done_tick`=0, `frame_err`=0;
  - synchronizer flops = 1.
- Reset mid-frame aborts the frame: no `rx_done_tick`, and `rx_data` is cleared.
- Pin-to-detect latency: an `rx` fall registered at edge t is seen as a start detect in cycle t+2. The state is START from t+3.
- Each bit is sampled `OVERSAMPLE`/2 ticks after its nominal start (±1 `s_tick` of jitter plus 3 `clk` cycles).
- `rx_done_tick` and `frame_err` are registered, exactly one cycle wide, and assert in the cycle after the final stop-bit `s_tick`. `rx_data` changes only in that same cycle.
- No backpressure. A consumer must capture `rx_data` before the next frame completes (≥ `DATA_BIT`+1+`STOP_BIT` bit periods later).

## Test plan
Bench drives `s_tick` every 4 clk cycles, 8N1 unless stated.
- Reset: `reset_n`=0 for 3 cycles → `rx_data`=0x00, `rx_done_tick`=0, `frame_err`=0. No pulse while `rx` idles high for 20 bit periods.
- Single frame 0xA5 → exactly one `rx_done_tick` and `rx_data`=0xA5, `frame_err`=0. The pulse lands 9.5 bit periods (±1 tick + 3 cycles) after the start edge.
- Glitch: `rx` low for 4 `s_tick`s, then high → no `rx_done_tick`, state back in IDLE. A following frame 0x3C is received as 0x3C.
- Framing error: frame 0x55 with stop bit 0, then `rx` held low for 40 bit periods → one pulse with `rx_data`=0x55, `frame_err`=1, and no further pulses. After `rx` returns high, frame 0x0F → 0x0F with `frame_err`=0.
- Back-to-back: 0x00, 0xFF, 0x81 with zero idle gap, then repeated with `STOP_BIT`=2 → three pulses each, correct data, `frame_err`=0. With `STOP_BIT`=2 and only the second stop bit 0 → `frame_err`=1.
- Reset mid-frame: `reset_n`=0 during data bit 3 of frame 0xC3 → no pulse, `rx_data`=0x00. The next full frame 0x81 is received as 0x81.
